// File: rtl/muldiv_unit.sv
`default_nettype none
// =============================================================================
// muldiv_unit : iterative RV32M multiply/divide, fixed 33-cycle latency.
// Divider datapath built only when MULDIV_DIV_EN is defined.    Rev 1.0
// =============================================================================
module muldiv_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   input  logic        flush_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] result_o,
   output logic        illegal_o
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e      state_q;
   logic [5:0]  cnt_q;
   logic [1:0]  op_q;
   logic        neg_q;
   logic [63:0] acc_q, acc_d;
   logic [31:0] mag_q;
   logic [31:0] result_q, result_d;
   logic        busy_q, done_q, illegal_q;

   logic        w_sa, w_sb, w_neg_a, w_neg_b, w_illegal, w_neg0;
   logic [31:0] w_abs_a, w_abs_b, w_mag0;
   logic [63:0] w_acc0;
   logic [32:0] w_sum;
   logic [63:0] w_prod;
`ifdef MULDIV_DIV_EN
   logic        div_q, bzero_q;
   logic [32:0] rem_q, rem_d;
   logic [33:0] w_trial;
   logic [31:0] w_quo, w_rem;
`endif

   // Operand signedness and launch values, derived from the incoming op.
   always_comb begin
      w_sa    = funct3_i[2] ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
      w_sb    = funct3_i[2] ? ~funct3_i[0] : ~funct3_i[1];
      w_neg_a = w_sa & op_a_i[31];
      w_neg_b = w_sb & op_b_i[31];
      w_abs_a = w_neg_a ? (~op_a_i + 32'd1) : op_a_i;
      w_abs_b = w_neg_b ? (~op_b_i + 32'd1) : op_b_i;
      w_acc0  = {32'd0, w_abs_b};
      w_mag0  = w_abs_a;
      w_neg0  = w_neg_a ^ w_neg_b;
`ifdef MULDIV_DIV_EN
      w_illegal = 1'b0;
      if (funct3_i[2]) begin
         w_acc0 = {32'd0, w_abs_a};
         w_mag0 = w_abs_b;
         w_neg0 = funct3_i[1] ? w_neg_a : (w_neg_a ^ w_neg_b);
      end
`else
      w_illegal = funct3_i[2];
`endif
   end

   // Multiply: acc = {partial sum, remaining multiplier}. Divide: acc[31:0]
   // shifts dividend bits out the top while quotient bits enter at the bottom.
   always_comb begin
      w_sum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_q} : 33'd0);
      acc_d    = {w_sum, acc_q[31:1]};
      w_prod   = neg_q ? (~acc_q + 64'd1) : acc_q;
      result_d = (op_q == 2'b00) ? w_prod[31:0] : w_prod[63:32];
`ifdef MULDIV_DIV_EN
      w_trial = {rem_q, acc_q[31]} - {2'b00, mag_q};
      rem_d   = w_trial[33] ? {rem_q[31:0], acc_q[31]} : w_trial[32:0];
      w_quo   = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
      w_rem   = neg_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
      if (div_q) begin
         acc_d = {32'd0, acc_q[30:0], ~w_trial[33]};
         if (op_q[1])
            result_d = w_rem;
         else if (bzero_q)
            result_d = 32'hFFFF_FFFF;
         else
            result_d = w_quo;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         neg_q     <= 1'b0;
         acc_q     <= '0;
         mag_q     <= '0;
         result_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
`ifdef MULDIV_DIV_EN
         div_q     <= 1'b0;
         bzero_q   <= 1'b0;
         rem_q     <= '0;
`endif
      end else begin
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         if (flush_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE, S_DONE: begin
                  if (start_i && w_illegal) begin
                     state_q   <= S_DONE;
                     done_q    <= 1'b1;
                     illegal_q <= 1'b1;
                     result_q  <= '0;
                  end else if (start_i) begin
                     state_q <= S_CALC;
                     busy_q  <= 1'b1;
                     cnt_q   <= '0;
                     op_q    <= funct3_i[1:0];
                     neg_q   <= w_neg0;
                     acc_q   <= w_acc0;
                     mag_q   <= w_mag0;
`ifdef MULDIV_DIV_EN
                     div_q   <= funct3_i[2];
                     bzero_q <= (op_b_i == 32'd0);
                     rem_q   <= '0;
`endif
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
               S_CALC: begin
                  acc_q <= acc_d;
`ifdef MULDIV_DIV_EN
                  rem_q <= rem_d;
`endif
                  cnt_q <= cnt_q + 6'd1;
                  if (cnt_q == 6'd31)
                     state_q <= S_FIX;
               end
               S_FIX: begin
                  result_q <= result_d;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= S_DONE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign result_o  = result_q;
   assign illegal_o = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// =============================================================================
// tb_muldiv_unit : directed self-checking bench for muldiv_unit.   Rev 1.0
// =============================================================================
module tb_muldiv_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [2:0]  funct3_i;
   logic [31:0] op_a_i;
   logic [31:0] op_b_i;
   logic        flush_i;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_o;
   logic        illegal_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   muldiv_unit dut (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start_i),
      .funct3_i  (funct3_i),
      .op_a_i    (op_a_i),
      .op_b_i    (op_b_i),
      .flush_i   (flush_i),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .result_o  (result_o),
      .illegal_o (illegal_o)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Holds start for one edge (E0); returns just after E0.
   task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start_i  = 1'b1;
      funct3_i = f3;
      op_a_i   = a;
      op_b_i   = b;
      @(posedge clk);
      #1;
      start_i  = 1'b0;
   endtask

   task automatic wait_done(output int lat, output int nbusy);
      lat   = 0;
      nbusy = 0;
      while (done_o !== 1'b1 && lat < 100) begin
         if (busy_o === 1'b1) nbusy++;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                         input logic exp_ill);
      int lat, nbusy;
      launch(f3, a, b);
      wait_done(lat, nbusy);
      check_val({tag, " latency"}, lat, exp_lat);
      check_val({tag, " busy cycles"}, nbusy, exp_lat);
      check_val({tag, " result"}, result_o, exp);
      check_val({tag, " illegal"}, {31'd0, illegal_o}, {31'd0, exp_ill});
      @(posedge clk);
      #1;
      check_val({tag, " done pulse"}, {31'd0, done_o}, 32'd0);
   endtask

   initial begin
      int lat, nbusy, nd;
      rst      = 1'b1;
      start_i  = 1'b0;
      flush_i  = 1'b0;
      funct3_i = 3'd0;
      op_a_i   = '0;
      op_b_i   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_val("reset busy", {31'd0, busy_o}, 32'd0);
      check_val("reset done", {31'd0, done_o}, 32'd0);
      check_val("reset result", result_o, 32'd0);
      check_val("reset illegal", {31'd0, illegal_o}, 32'd0);

      run_op("MUL 7*-3",     3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0);
      run_op("MULH min*min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b0);
      run_op("MULHU max",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
      run_op("MULHSU -1*2",  3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33, 1'b0);
      run_op("MUL hex",      3'b000, 32'h1234_5678, 32'h10,        32'h2345_6780, 33, 1'b0);
      run_op("MULH -1*-1",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b0);

`ifdef MULDIV_DIV_EN
      run_op("DIV -7/2",     3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 1'b0);
      run_op("REM -7/2",     3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 1'b0);
      run_op("DIVU 100/7",   3'b101, 32'd100,       32'd7,         32'd14,        33, 1'b0);
      run_op("REMU 100/7",   3'b111, 32'd100,       32'd7,         32'd2,         33, 1'b0);
      run_op("DIV 5/0",      3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 33, 1'b0);
      run_op("DIV -5/0",     3'b100, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 33, 1'b0);
      run_op("REMU 5/0",     3'b111, 32'd5,         32'd0,         32'd5,         33, 1'b0);
      run_op("DIV ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1'b0);
      run_op("REM ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33, 1'b0);
`else
      run_op("DIVU illegal", 3'b101, 32'd9,         32'd3,         32'd0,         0,  1'b1);
      run_op("MUL 3*4",      3'b000, 32'd3,         32'd4,         32'd12,        33, 1'b0);
      run_op("REM illegal",  3'b110, 32'd9,         32'd3,         32'd0,         0,  1'b1);
`endif

      // Flush mid-CALC, restart, and a stray start during CALC that must be ignored.
      run_op("MUL 9*9", 3'b000, 32'd9, 32'd9, 32'd81, 33, 1'b0);
      launch(3'b000, 32'd5, 32'd6);
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush_i = 1'b1;
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      check_val("flush busy", {31'd0, busy_o}, 32'd0);
      check_val("flush done", {31'd0, done_o}, 32'd0);
      check_val("flush result kept", result_o, 32'd81);
      launch(3'b000, 32'd6, 32'd7);
      repeat (4) @(posedge clk);
      @(negedge clk);
      start_i  = 1'b1;
      funct3_i = 3'b011;
      op_a_i   = 32'hFFFF_FFFF;
      op_b_i   = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      wait_done(lat, nbusy);
      check_val("restart latency", lat + 5, 32'd33);
      check_val("restart result", result_o, 32'd42);

      // Back-to-back: start while done is high.
      @(posedge clk);
      #1;
      launch(3'b000, 32'd100, 32'd100);
      wait_done(lat, nbusy);
      check_val("b2b first latency", lat, 32'd33);
      check_val("b2b first result", result_o, 32'd10000);
      launch(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check_val("b2b relaunch busy", {31'd0, busy_o}, 32'd1);
      wait_done(lat, nbusy);
      check_val("b2b second latency", lat, 32'd33);
      check_val("b2b second result", result_o, 32'd1);

      // Flush together with start: flush wins, nothing launches.
      @(posedge clk);
      #1;
      @(negedge clk);
      start_i  = 1'b1;
      flush_i  = 1'b1;
      funct3_i = 3'b000;
      op_a_i   = 32'd2;
      op_b_i   = 32'd2;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      flush_i = 1'b0;
      check_val("flush+start busy", {31'd0, busy_o}, 32'd0);

      // Reset mid-operation discards the op.
      launch(3'b000, 32'd3, 32'd3);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_val("midop reset busy", {31'd0, busy_o}, 32'd0);
      check_val("midop reset result", result_o, 32'd0);
      nd = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done_o === 1'b1) nd++;
      end
      check_val("no done after abort", nd, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
